icmp_echo_reply8: RTL and testbench



---
 rtl/icmp_pkg.sv | 17 +
 rtl/icmp_echo_buf8.sv | 22 ++
 rtl/icmp_echo_reply8.sv | 186 ++++++++++++++++++
 tb/tb_icmp_echo_reply8.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icmp_pkg.sv
// Shared ICMP echo constants, FSM state type and checksum helper.
package icmp_pkg;

  localparam logic [7:0] ICMP_ECHO_REQUEST = 8'd8;
  localparam logic [7:0] ICMP_ECHO_REPLY   = 8'd0;
  localparam int         ICMP_HDR_LEN      = 4;

  typedef enum logic [1:0] {IDLE, RX, SEND, DISCARD} state_t;

  // 16-bit one's-complement add: the carry out is folded back into bit 0
  function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[15:0] + {15'd0, sum[16]};
  endfunction

endpackage

// File: rtl/icmp_echo_buf8.sv
// Simple dual-port echo body RAM: one write port, one registered read port.
module icmp_echo_buf8 #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/icmp_echo_reply8.sv
// ICMP echo responder: buffers an echo request body and streams back the reply.
// Define ICMP_ECHO_STATS_EN to implement drop_count / reply_count (otherwise tied to 0).
module icmp_echo_reply8
  import icmp_pkg::*;
#(
  parameter int AVL_SIZE  = 8,
  parameter int BYTE_SIZE = 8,
  parameter int BUF_DEPTH = 64,
  parameter int BUF_AW    = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 data_in_valid,
  input  logic [AVL_SIZE-1:0]  data_in,
  input  logic                 frame_end,
  input  logic                 frame_abort,
  input  logic [7:0]           icmp_type,
  input  logic [7:0]           code,
  input  logic [15:0]          checksum,
  input  logic                 tx_ready,
  output logic                 tx_valid,
  output logic [BYTE_SIZE-1:0] tx_data,
  output logic                 tx_last,
  output logic                 busy,
  output logic [15:0]          drop_count,
  output logic [15:0]          reply_count
);

  localparam int IDX_W = BUF_AW + 3;
  localparam int POS_W = BUF_AW + 1;
  localparam logic [IDX_W-1:0] IDX_MAX   = '1;
  localparam logic [IDX_W-1:0] HDR_IDX   = IDX_W'(ICMP_HDR_LEN);
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(BUF_DEPTH);
  // Type 8 -> 0 removes 0x0800 from the sum, so the complemented checksum gains 0x0800
  localparam logic [15:0] TYPE_DELTA = 16'h0800;

  state_t state, state_next;
  logic [IDX_W-1:0] idx, body_addr;
  logic ovf, hdr_pending;
  logic [7:0] type_q, code_q;
  logic [15:0] cks_q, reply_cks;
  logic [POS_W-1:0] len_q, pos, pos_next;
  logic in_rx, rx_byte, last_byte, over_now, wr_en, accept;
  logic tx_xfer, tx_done, tx_advance, still_sending;
  logic [BUF_AW-1:0] rd_addr;
  logic [BYTE_SIZE-1:0] rd_data, next_byte;

  assign in_rx         = (state == IDLE) || (state == RX);
  assign rx_byte       = data_in_valid && in_rx && !frame_abort;
  assign last_byte     = rx_byte && frame_end;
  assign body_addr     = idx - HDR_IDX;
  assign over_now      = rx_byte && (idx >= HDR_IDX) && (body_addr >= DEPTH_IDX);
  assign wr_en         = rx_byte && (idx >= HDR_IDX) && !over_now;
  assign accept        = last_byte && (state == RX) && (type_q == ICMP_ECHO_REQUEST) &&
                         (code_q == 8'd0) && (idx >= HDR_IDX + IDX_W'(3)) && !ovf && !over_now;
  assign tx_xfer       = tx_valid && tx_ready;
  assign tx_done       = tx_xfer && tx_last;
  assign tx_advance    = tx_xfer && !tx_last;
  assign still_sending = tx_valid && !tx_done;
  assign reply_cks     = ones_add16(cks_q, TYPE_DELTA);
  assign busy          = tx_valid;

  // Decoder fields are only valid the cycle after byte 3, hence the one-cycle pending flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx         <= '0;
      ovf         <= 1'b0;
      hdr_pending <= 1'b0;
      type_q      <= '0;
      code_q      <= '0;
      cks_q       <= '0;
      len_q       <= '0;
    end else begin
      hdr_pending <= rx_byte && (idx == HDR_IDX - IDX_W'(1));
      if (hdr_pending) begin
        type_q <= icmp_type;
        code_q <= code;
        cks_q  <= checksum;
      end
      if (accept) len_q <= POS_W'(idx - HDR_IDX + IDX_W'(1));
      if (!in_rx || frame_abort || last_byte) begin
        idx <= '0;
        ovf <= 1'b0;
      end else if (rx_byte) begin
        if (idx != IDX_MAX) idx <= idx + IDX_W'(1);
        if (over_now) ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // A new message during a reply is swallowed in DISCARD while the reply keeps streaming
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rx_byte && !frame_end) state_next = RX;
      RX: begin
        if (frame_abort)    state_next = IDLE;
        else if (last_byte) state_next = accept ? SEND : IDLE;
      end
      SEND: begin
        if (data_in_valid && !frame_end) state_next = DISCARD;
        else if (tx_done)                state_next = IDLE;
      end
      DISCARD: begin
        if (frame_abort || (data_in_valid && frame_end))
          state_next = still_sending ? SEND : IDLE;
      end
    endcase
  end

  icmp_echo_buf8 #(
    .DEPTH(BUF_DEPTH),
    .AW   (BUF_AW),
    .DW   (BYTE_SIZE)
  ) u_buf (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(body_addr[BUF_AW-1:0]),
    .wr_data(data_in),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // RAM is addressed one byte ahead of the output register so full-rate bursts have no bubbles
  always_comb begin
    pos_next = pos;
    if (accept)          pos_next = '0;
    else if (tx_advance) pos_next = pos + POS_W'(1);
    rd_addr   = BUF_AW'(pos_next - POS_W'(ICMP_HDR_LEN - 1));
    next_byte = rd_data;
    if (pos_next == POS_W'(0))      next_byte = ICMP_ECHO_REPLY;
    else if (pos_next == POS_W'(1)) next_byte = 8'h00;
    else if (pos_next == POS_W'(2)) next_byte = reply_cks[15:8];
    else if (pos_next == POS_W'(3)) next_byte = reply_cks[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
      tx_last  <= 1'b0;
      pos      <= '0;
    end else begin
      pos <= pos_next;
      if (accept || tx_advance) begin
        tx_data <= next_byte;
        tx_last <= !accept && (pos_next == len_q + POS_W'(3));
      end
      if (accept) begin
        tx_valid <= 1'b1;
      end else if (tx_done) begin
        tx_valid <= 1'b0;
        tx_last  <= 1'b0;
      end
    end
  end

`ifdef ICMP_ECHO_STATS_EN
  logic [15:0] drop_q, reply_q;
  logic drop_inc;

  assign drop_inc = data_in_valid && frame_end && !in_rx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q  <= '0;
      reply_q <= '0;
    end else begin
      if (drop_inc && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      if (tx_done) reply_q <= reply_q + 16'd1;
    end
  end

  assign drop_count  = drop_q;
  assign reply_count = reply_q;
`else
  assign drop_count  = '0;
  assign reply_count = '0;
`endif

endmodule

// File: tb/tb_icmp_echo_reply8.sv
// Scoreboard bench for icmp_echo_reply8: directed requests, expected reply bytes queued at issue.
module tb_icmp_echo_reply8;
  import icmp_pkg::*;

`ifdef ICMP_ECHO_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        data_in_valid = 1'b0;
  logic [7:0]  data_in = '0;
  logic        frame_end = 1'b0;
  logic        frame_abort = 1'b0;
  logic [7:0]  icmp_type = 8'd13;
  logic [7:0]  code = 8'h55;
  logic [15:0] checksum = 16'hDEAD;
  logic        tx_ready = 1'b1;
  logic        tx_valid, tx_last, busy;
  logic [7:0]  tx_data;
  logic [15:0] drop_count, reply_count;

  int tests = 0;
  int fails = 0;
  int exp_replies = 0;
  int ready_mode = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_b;
  logic [7:0] body_buf [0:127];
  logic       hold_chk = 1'b0;
  logic [9:0] held;

  icmp_echo_reply8 dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_in_valid(data_in_valid),
    .data_in      (data_in),
    .frame_end    (frame_end),
    .frame_abort  (frame_abort),
    .icmp_type    (icmp_type),
    .code         (code),
    .checksum     (checksum),
    .tx_ready     (tx_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_last      (tx_last),
    .busy         (busy),
    .drop_count   (drop_count),
    .reply_count  (reply_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready pattern: 0 = always ready, 1 = random stalls, 2 = held off
  initial forever begin
    @(posedge clk);
    #1;
    if (ready_mode == 0)      tx_ready = 1'b1;
    else if (ready_mode == 1) tx_ready = 1'($urandom_range(0, 1));
    else                      tx_ready = 1'b0;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) check_output("stall_hold", {tx_valid, tx_last, tx_data}, held);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_byte: got %0h last %0b, none expected", tx_data, tx_last);
        end else begin
          exp_b = exp_q.pop_front();
          check_output("reply_byte", {tx_last, tx_data}, exp_b);
        end
      end
      hold_chk = tx_valid && !tx_ready;
      held = {tx_valid, tx_last, tx_data};
    end
  end

  task automatic set_fields(input bit real_hdr, input logic [7:0] typ, input logic [7:0] cod,
                            input logic [15:0] cks);
    icmp_type = real_hdr ? typ : 8'd13;
    code      = real_hdr ? cod : 8'h55;
    checksum  = real_hdr ? cks : 16'hDEAD;
  endtask

  task automatic apply_stimulus(input logic [7:0] typ, input logic [7:0] cod, input logic [15:0] cks,
                                input int blen, input int abort_at, input bit expect_reply,
                                input logic [15:0] exp_cks);
    int n;
    logic [7:0] b;
    n = 4 + blen;
    if (expect_reply) begin
      exp_q.push_back(9'h000);
      exp_q.push_back(9'h000);
      exp_q.push_back({1'b0, exp_cks[15:8]});
      exp_q.push_back({1'b0, exp_cks[7:0]});
      for (int i = 0; i < blen; i++) exp_q.push_back({(i == blen - 1), body_buf[i]});
      exp_replies++;
    end
    for (int i = 0; i < n; i++) begin
      case (i)
        0:       b = typ;
        1:       b = cod;
        2:       b = cks[15:8];
        3:       b = cks[7:0];
        default: b = body_buf[i - 4];
      endcase
      data_in_valid = 1'b1;
      data_in       = b;
      frame_end     = (i == n - 1);
      frame_abort   = (i == abort_at);
      set_fields(i == 4, typ, cod, cks);
      @(posedge clk);
      #1;
      if (i == abort_at) break;
    end
    data_in_valid = 1'b0;
    frame_end     = 1'b0;
    frame_abort   = 1'b0;
    set_fields((n == 4) && (abort_at < 0), typ, cod, cks);
    if (expect_reply) begin
      check_output("latency_valid", tx_valid, 1);
      check_output("busy_in_send", busy, 1);
    end
    @(posedge clk);
    #1;
    set_fields(1'b0, typ, cod, cks);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (exp_q.size() == 0 && !tx_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL %s timeout: %0d bytes outstanding, tx_valid %0b", name, exp_q.size(), tx_valid);
    end
  endtask

  task automatic check_rejected(input string name);
    repeat (4) @(posedge clk);
    #1;
    check_output({name, "_no_valid"}, tx_valid, 0);
    check_output({name, "_idle"}, dut.state, IDLE);
  endtask

  task automatic load_body_a();
    body_buf[0] = 8'h01; body_buf[1] = 8'h02; body_buf[2] = 8'h00;
    body_buf[3] = 8'h05; body_buf[4] = 8'hAA; body_buf[5] = 8'hBB;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("rst_tx_valid", tx_valid, 0);
    check_output("rst_tx_data", tx_data, 0);
    check_output("rst_tx_last", tx_last, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_drop_count", drop_count, 0);
    check_output("rst_reply_count", reply_count, 0);

    load_body_a();
    apply_stimulus(8'd8, 8'd0, 16'hF7FF, 6, -1, 1'b1, 16'hFFFF);
    wait_idle("basic");
    check_output("basic_reply_count", reply_count, STATS * exp_replies);

    body_buf[0] = 8'h11; body_buf[1] = 8'h22; body_buf[2] = 8'h33; body_buf[3] = 8'h44;
    apply_stimulus(8'd8, 8'd0, 16'hF800, 4, -1, 1'b1, 16'h0001);
    wait_idle("carry");

    ready_mode = 1;
    load_body_a();
    apply_stimulus(8'd8, 8'd0, 16'hF7FF, 6, -1, 1'b1, 16'hFFFF);
    wait_idle("stalls");
    ready_mode = 0;

    apply_stimulus(8'd13, 8'd0, 16'hF7FF, 6, -1, 1'b0, 16'h0000);
    check_rejected("type13");
    apply_stimulus(8'd8, 8'd0, 16'hF7FF, 0, -1, 1'b0, 16'h0000);
    check_rejected("len4");
    apply_stimulus(8'd8, 8'd0, 16'hF7FF, 3, -1, 1'b0, 16'h0000);
    check_rejected("body3");

    for (int i = 0; i < 65; i++) body_buf[i] = 8'(i) ^ 8'h5A;
    apply_stimulus(8'd8, 8'd0, 16'h1234, 65, -1, 1'b0, 16'h0000);
    check_rejected("overflow");
    apply_stimulus(8'd8, 8'd0, 16'h1234, 64, -1, 1'b1, 16'h1A34);
    wait_idle("full_buffer");

    ready_mode = 2;
    load_body_a();
    apply_stimulus(8'd8, 8'd0, 16'hF7FF, 6, -1, 1'b1, 16'hFFFF);
    apply_stimulus(8'd8, 8'd0, 16'hF7FF, 6, -1, 1'b0, 16'h0000);
    ready_mode = 0;
    wait_idle("drop");
    check_output("drop_count", drop_count, STATS * 1);
    check_output("drop_reply_count", reply_count, STATS * exp_replies);

    apply_stimulus(8'd8, 8'd0, 16'hF7FF, 6, 6, 1'b0, 16'h0000);
    check_rejected("abort");
    apply_stimulus(8'd8, 8'd0, 16'hF7FF, 6, -1, 1'b1, 16'hFFFF);
    wait_idle("after_abort");
    check_output("abort_reply_count", reply_count, STATS * exp_replies);

    ready_mode = 2;
    apply_stimulus(8'd8, 8'd0, 16'hF7FF, 6, -1, 1'b1, 16'hFFFF);
    #1;
    reset_n = 1'b0;
    #1;
    check_output("midsend_tx_valid", tx_valid, 0);
    check_output("midsend_tx_data", tx_data, 0);
    check_output("midsend_tx_last", tx_last, 0);
    check_output("midsend_busy", busy, 0);
    check_output("midsend_reply_count", reply_count, 0);
    check_output("midsend_drop_count", drop_count, 0);
    check_output("midsend_state", dut.state, IDLE);
    exp_q.delete();
    exp_replies = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    ready_mode = 0;
    body_buf[0] = 8'h11; body_buf[1] = 8'h22; body_buf[2] = 8'h33; body_buf[3] = 8'h44;
    apply_stimulus(8'd8, 8'd0, 16'hF800, 4, -1, 1'b1, 16'h0001);
    wait_idle("after_reset");
    check_output("final_reply_count", reply_count, STATS * exp_replies);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
